// File: rtl/mem_pattern_tester.sv
// mem_pattern_tester: burst write/read-back pattern generator and checker for the PL memory controller.
module mem_pattern_tester #(
  parameter int MEM_DATA_BITS = 64,
  parameter int ADDR_BITS     = 32,
  parameter int BURST_LEN     = 128,
  parameter int CNT_BITS      = 32
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [1:0]               cfg_mode,
  input  logic [ADDR_BITS-1:0]     cfg_base,
  input  logic [31:0]              cfg_bursts,
  input  logic                     cfg_loop,
  output logic                     wr_burst_req,
  output logic                     rd_burst_req,
  output logic [9:0]               wr_burst_len,
  output logic [9:0]               rd_burst_len,
  output logic [ADDR_BITS-1:0]     wr_burst_addr,
  output logic [ADDR_BITS-1:0]     rd_burst_addr,
  input  logic                     wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_finish,
  input  logic                     rd_burst_finish,
  input  logic                     rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [CNT_BITS-1:0]      err_cnt,
  output logic [CNT_BITS-1:0]      pass_cnt,
  output logic [ADDR_BITS-1:0]     first_err_addr
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  localparam logic [31:0] BL = 32'(BURST_LEN);
  state_t state;
  logic [1:0] mode;
  logic [ADDR_BITS-1:0] base;
  logic [31:0] bursts, bi, kb, kw, kr;
  logic loop, mis, last;
  function automatic logic [MEM_DATA_BITS-1:0] pat(input logic [1:0] m, input logic [31:0] k);
    logic [MEM_DATA_BITS-1:0] b, l, o;
    b = {(MEM_DATA_BITS/8){k[7:0]}};
    l = {(MEM_DATA_BITS/32){k}};
    o = {{(MEM_DATA_BITS-1){1'b0}}, 1'b1} << (k % 32'(MEM_DATA_BITS));
    return m == 2'd0 ? b : m == 2'd1 ? l : m == 2'd2 ? o : ~b;
  endfunction
  assign wr_burst_len = 10'(BURST_LEN);
  assign rd_burst_len = 10'(BURST_LEN);
  assign mis = state == READ && rd_burst_data_valid && rd_burst_data != pat(mode, kr);
  assign last = bi == bursts - 32'd1;
  // Beat-index realignment in the state case overrides the per-beat increments above it.
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state <= IDLE;
      mode <= '0;
      base <= '0;
      bursts <= '0;
      loop <= 1'b0;
      bi <= '0;
      kb <= '0;
      kw <= '0;
      kr <= '0;
      wr_burst_req <= 1'b0;
      rd_burst_req <= 1'b0;
      wr_burst_addr <= '0;
      rd_burst_addr <= '0;
      wr_burst_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      err_cnt <= '0;
      pass_cnt <= '0;
      first_err_addr <= '0;
    end else begin
      if (state == WRITE && wr_burst_data_req) begin
        wr_burst_data <= pat(mode, kw);
        kw <= kw + 32'd1;
      end
      if (state == READ && rd_burst_data_valid) kr <= kr + 32'd1;
      if (mis) begin
        error <= 1'b1;
        err_cnt <= err_cnt == '1 ? err_cnt : err_cnt + 1'b1;
        if (!error) first_err_addr <= rd_burst_addr + ADDR_BITS'(kr - kb);
      end
      case (state)
        IDLE: if (start) begin
          mode <= cfg_mode;
          base <= cfg_base;
          bursts <= cfg_bursts == 32'd0 ? 32'd1 : cfg_bursts;
          loop <= cfg_loop;
          bi <= '0;
          kb <= '0;
          kw <= '0;
          kr <= '0;
          wr_burst_addr <= cfg_base;
          wr_burst_req <= 1'b1;
          error <= 1'b0;
          err_cnt <= '0;
          pass_cnt <= '0;
          first_err_addr <= '0;
          busy <= 1'b1;
          state <= WRITE;
        end
        WRITE: if (wr_burst_finish) begin
          wr_burst_req <= 1'b0;
          rd_burst_req <= 1'b1;
          rd_burst_addr <= wr_burst_addr;
          kw <= kb;
          kr <= kb;
          state <= READ;
        end
        READ: if (rd_burst_finish) begin
          rd_burst_req <= 1'b0;
          if (stop || (last && !loop)) begin
            if (!stop) pass_cnt <= pass_cnt + 1'b1;
            done <= 1'b1;
            busy <= 1'b0;
            state <= DONE;
          end else if (!last) begin
            bi <= bi + 32'd1;
            kb <= kb + BL;
            kw <= kb + BL;
            kr <= kb + BL;
            wr_burst_addr <= wr_burst_addr + ADDR_BITS'(BURST_LEN);
            wr_burst_req <= 1'b1;
            state <= WRITE;
          end else begin
            pass_cnt <= pass_cnt + 1'b1;
            bi <= '0;
            kb <= '0;
            kw <= '0;
            kr <= '0;
            wr_burst_addr <= base;
            wr_burst_req <= 1'b1;
            state <= WRITE;
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_pattern_tester.sv
// tb_mem_pattern_tester: directed scenarios against an ideal burst controller with a write-data scoreboard.
module tb_mem_pattern_tester;
  localparam int BL = 128;
  logic mem_clk = 0, rst = 1, start = 0, stop = 0, cfg_loop = 0;
  logic [1:0] cfg_mode = 0;
  logic [31:0] cfg_base = 0, cfg_bursts = 0;
  logic wr_burst_req, rd_burst_req, wr_burst_data_req = 0, wr_burst_finish = 0;
  logic rd_burst_finish = 0, rd_burst_data_valid = 0;
  logic [9:0] wr_burst_len, rd_burst_len;
  logic [31:0] wr_burst_addr, rd_burst_addr, first_err_addr;
  logic [63:0] wr_burst_data, rd_burst_data = 0;
  logic busy, done, error;
  logic [3:0] err_cnt, pass_cnt;
  logic [63:0] exp_q[$];
  logic [63:0] buffer [BL];
  int vectors = 0, miscompares = 0;

  mem_pattern_tester #(.MEM_DATA_BITS(64), .ADDR_BITS(32), .BURST_LEN(BL), .CNT_BITS(4)) dut (
    .mem_clk(mem_clk), .rst(rst), .start(start), .stop(stop), .cfg_mode(cfg_mode),
    .cfg_base(cfg_base), .cfg_bursts(cfg_bursts), .cfg_loop(cfg_loop),
    .wr_burst_req(wr_burst_req), .rd_burst_req(rd_burst_req),
    .wr_burst_len(wr_burst_len), .rd_burst_len(rd_burst_len),
    .wr_burst_addr(wr_burst_addr), .rd_burst_addr(rd_burst_addr),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
    .wr_burst_finish(wr_burst_finish), .rd_burst_finish(rd_burst_finish),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
    .busy(busy), .done(done), .error(error), .err_cnt(err_cnt), .pass_cnt(pass_cnt),
    .first_err_addr(first_err_addr));

  always #5 mem_clk = ~mem_clk;

  function automatic logic [63:0] pat(input logic [1:0] m, input logic [31:0] k);
    logic [63:0] b = {8{k[7:0]}};
    case (m)
      2'd0: return b;
      2'd1: return {k, k};
      2'd2: return 64'd1 << k[5:0];
      default: return ~b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input bit rd);
    int n = 0;
    while ((rd ? rd_burst_req : wr_burst_req) !== 1'b1 && n < 20) begin
      @(negedge mem_clk);
      n++;
    end
    chk(rd ? "rd_req_seen" : "wr_req_seen", {63'd0, rd ? rd_burst_req : wr_burst_req}, 64'd1);
  endtask

  task automatic go(input logic [1:0] m, input logic [31:0] b, input logic [31:0] n, input logic lp);
    cfg_mode = m; cfg_base = b; cfg_bursts = n; cfg_loop = lp;
    start = 1;
    @(negedge mem_clk);
    start = 0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [31:0] k0, input logic [1:0] m);
    logic [63:0] got;
    wait_req(0);
    chk("wr_addr", wr_burst_addr, addr);
    for (int i = 0; i < BL; i++) begin
      wr_burst_data_req = 1;
      exp_q.push_back(pat(m, k0 + i));
      @(negedge mem_clk);
      got = wr_burst_data;
      buffer[i] = got;
      if (got !== exp_q[0]) chk("wr_data", got, exp_q[0]);
      void'(exp_q.pop_front());
    end
    wr_burst_data_req = 0;
    wr_burst_finish = 1;
    @(negedge mem_clk);
    wr_burst_finish = 0;
  endtask

  task automatic read_burst(input logic [31:0] addr, input int bad);
    wait_req(1);
    chk("rd_addr", rd_burst_addr, addr);
    for (int i = 0; i < BL; i++) begin
      rd_burst_data_valid = 1;
      rd_burst_data = buffer[i] ^ ((bad == -2 || bad == i) ? 64'h1 : 64'h0);
      rd_burst_finish = (i == BL - 1);
      @(negedge mem_clk);
    end
    rd_burst_data_valid = 0;
    rd_burst_finish = 0;
  endtask

  task automatic end_checks(input logic [3:0] passes, input logic err);
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("busy_at_done", {63'd0, busy}, 64'd0);
    chk("pass_cnt", pass_cnt, passes);
    chk("error", {63'd0, error}, {63'd0, err});
    @(negedge mem_clk);
    chk("done_cleared", {63'd0, done}, 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge mem_clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_wr_req", {63'd0, wr_burst_req}, 64'd0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_wr_len", wr_burst_len, BL);
    chk("rst_rd_len", rd_burst_len, BL);
    chk("rst_first_err", first_err_addr, 0);
    rst = 0;
    @(negedge mem_clk);

    go(2'd0, 32'h0200_0000, 32'd2, 1'b0);
    write_burst(32'h0200_0000, 0, 2'd0);
    read_burst(32'h0200_0000, -1);
    write_burst(32'h0200_0080, 128, 2'd0);
    chk("beat_ff", buffer[127], 64'hFFFF_FFFF_FFFF_FFFF);
    read_burst(32'h0200_0080, -1);
    end_checks(4'd1, 1'b0);

    go(2'd1, 32'h0000_1000, 32'd2, 1'b0);
    write_burst(32'h1000, 0, 2'd1);
    read_burst(32'h1000, -1);
    write_burst(32'h1080, 128, 2'd1);
    read_burst(32'h1080, 5);
    end_checks(4'd1, 1'b1);
    chk("inj_err_cnt", err_cnt, 1);
    chk("inj_first_addr", first_err_addr, 32'h1085);

    go(2'd2, 32'h0000_2000, 32'd0, 1'b0);
    write_burst(32'h2000, 0, 2'd2);
    chk("walk_beat64", buffer[64], 64'h1);
    chk("walk_beat63", buffer[63], 64'h8000_0000_0000_0000);
    read_burst(32'h2000, -1);
    end_checks(4'd1, 1'b0);

    go(2'd3, 32'h0000_3000, 32'd3, 1'b1);
    for (int b = 0; b < 3; b++) begin
      write_burst(32'h3000 + b * BL, b * BL, 2'd3);
      read_burst(32'h3000 + b * BL, -1);
    end
    chk("loop_pass1", pass_cnt, 1);
    chk("loop_busy", {63'd0, busy}, 64'd1);
    write_burst(32'h3000, 0, 2'd3);
    read_burst(32'h3000, -1);
    stop = 1;
    write_burst(32'h3080, 128, 2'd3);
    read_burst(32'h3080, -1);
    stop = 0;
    end_checks(4'd1, 1'b0);
    repeat (3) @(negedge mem_clk);
    chk("stop_no_restart", {63'd0, wr_burst_req}, 64'd0);

    go(2'd0, 32'h0000_5000, 32'd2, 1'b0);
    wait_req(0);
    for (int i = 0; i < 3; i++) begin
      wr_burst_data_req = 1;
      @(negedge mem_clk);
      chk("pre_rst_data", wr_burst_data, pat(2'd0, i));
    end
    rst = 1;
    @(negedge mem_clk);
    chk("mid_rst_wr_req", {63'd0, wr_burst_req}, 64'd0);
    chk("mid_rst_rd_req", {63'd0, rd_burst_req}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_pass", pass_cnt, 0);
    chk("mid_rst_err", err_cnt, 0);
    rst = 0;
    wr_burst_data_req = 0;
    exp_q.delete();
    @(negedge mem_clk);
    go(2'd1, 32'h0000_6000, 32'd1, 1'b0);
    write_burst(32'h6000, 0, 2'd1);
    read_burst(32'h6000, -1);
    end_checks(4'd1, 1'b0);

    go(2'd0, 32'h0000_7000, 32'd2, 1'b0);
    write_burst(32'h7000, 0, 2'd0);
    cfg_mode = 2'd2; cfg_base = 32'h0; cfg_bursts = 32'd5;
    start = 1;
    @(negedge mem_clk);
    start = 0;
    read_burst(32'h7000, -2);
    write_burst(32'h7080, 128, 2'd0);
    read_burst(32'h7080, -1);
    end_checks(4'd1, 1'b1);
    chk("sat_err_cnt", err_cnt, 15);
    chk("sat_first_addr", first_err_addr, 32'h7000);
    chk("sat_no_restart", {63'd0, wr_burst_req}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_pattern_tester.md
Name: mem_pattern_tester

Overview:
Parametrised DDR traffic generator and checker that drives the burst read/write interface of the PL memory controller. It fills a programmable region burst by burst and reads each burst back immediately. Read data is compared against one of four selectable data patterns. Error count and first-failing address are kept, and the test can loop continuously for soak testing.

Parameters:
MEM_DATA_BITS, 64, burst data width; must be a multiple of 32.
ADDR_BITS, 32, burst address width.
BURST_LEN, 128, beats per burst; legal range 1..1023.
CNT_BITS, 32, width of err_cnt and pass_cnt.

Ports:
mem_clk  in  1  single clock for all logic.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; begins a test when idle.
stop  in  1  level; request to end the test at the next burst boundary.
cfg_mode  in  2  pattern select, sampled on start.
cfg_base  in  ADDR_BITS  region start address (beat units), sampled on start.
cfg_bursts  in  32  number of bursts per pass (0 is treated as 1), sampled on start.
cfg_loop  in  1  1 = repeat passes until stop; sampled on start.
wr_burst_req, rd_burst_req  out  1  burst requests.
wr_burst_len, rd_burst_len  out  10  burst length, always BURST_LEN.
wr_burst_addr, rd_burst_addr  out  ADDR_BITS  burst start address.
wr_burst_data_req  in  1  controller requests the next write beat.
wr_burst_data  out  MEM_DATA_BITS  write beat, registered.
wr_burst_finish, rd_burst_finish  in  1  burst complete.
rd_burst_data_valid  in  1  read beat valid.
rd_burst_data  in  MEM_DATA_BITS  read beat.
busy  out  1  high from start acceptance until DONE.
done  out  1  one-cycle pulse at test end.
error  out  1  sticky mismatch flag.
err_cnt  out  CNT_BITS  mismatching beats, saturating.
pass_cnt  out  CNT_BITS  completed passes, wraps.
first_err_addr  out  ADDR_BITS  address of first mismatching beat.

Behaviour:
- Reset values:
  - All outputs 0, except wr_burst_len and rd_burst_len = BURST_LEN.
  - State IDLE. Reset mid-burst drops both requests on the next edge, with no handshake completion.
- States: IDLE, WRITE, READ, DONE.
  - IDLE to WRITE on start. Latch cfg, set wr_burst_addr = cfg_base and wr_burst_req = 1. Clear error, err_cnt, pass_cnt, first_err_addr and the beat index k. Set busy = 1.
  - WRITE to READ on wr_burst_finish. wr_burst_req goes 0, rd_burst_req goes 1, rd_burst_addr = wr_burst_addr.
  - READ on rd_burst_finish, in this priority order:
    - stop = 1: go to DONE.
    - Otherwise, not the last burst of the pass: go to WRITE with addr += BURST_LEN.
    - Otherwise, last burst: increment pass_cnt. If cfg_loop, go to WRITE with addr = cfg_base and k = 0; else go to DONE.
    - In every case rd_burst_req goes 0.
  - DONE: pulse done for one cycle, busy = 0, go to IDLE.
- Requests stay high until their finish is seen; finish outside the matching state is ignored.
- start while busy is ignored.
- Pattern P(k) uses the beat index k within the pass, 0..cfg_bursts*BURST_LEN-1, 32-bit wrap.
  - mode 0: byte k[7:0] replicated across the word.
  - mode 1: 32-bit k replicated in every 32-bit lane.
  - mode 2: walking one, bit (k mod MEM_DATA_BITS) set, all others 0.
  - mode 3: bitwise inverse of mode 0.
- Write path: on each wr_burst_data_req in WRITE, wr_burst_data <= P(kw) and kw increments, so data is valid on the cycle after req. kw realigns to the burst base on wr_burst_finish.
- Read path: on each rd_burst_data_valid in READ, compare against P(kr) and increment kr.
  - On mismatch: error <= 1 and err_cnt increments, saturating at all ones.
  - On the first mismatch of the test, first_err_addr <= rd_burst_addr + beat offset within the burst.
  - kr realigns to the burst base on rd_burst_finish.
- Valid beats with rd_burst_data_valid and rd_burst_finish in the same cycle are checked before the transition.
- Burst address arithmetic is modulo 2^ADDR_BITS and wraps silently.

Test Plan:
- Basic pass: mode 0, cfg_base = 0x2000000, cfg_bursts = 2, cfg_loop = 0, ideal controller model.
  - Writes at 0x2000000 and 0x2000080, beats 0x00..0xFF replicated.
  - Expect pass_cnt = 1, done pulse, error = 0.
- Injected error: mode 1, corrupt beat 5 of burst 1.
  - Expect err_cnt = 1, error = 1, first_err_addr = base + 0x85.
- Walking one: mode 2, MEM_DATA_BITS = 64, one burst.
  - Beat 64 = 0x1, beat 63 = 0x8000_0000_0000_0000; no errors.
- Loop and stop: cfg_loop = 1, 3 bursts; assert stop during burst 2 of pass 2.
  - Test ends after that read completes; pass_cnt = 1; done pulses once.
- Reset during WRITE with wr_burst_data_req active.
  - Both requests 0 the next cycle, all counters 0, busy = 0.
  - A fresh start then restarts at cfg_base.
- Saturation and ignore: force all beats wrong with CNT_BITS = 4.
  - err_cnt sticks at 15.
  - start pulsed mid-test is ignored: cfg unchanged, no restart.
